// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// ID-stage hazard and stall controller for the 5-stage RV32 pipeline.
//  - Inserts bubbles (NoOp_o) on load-use hazards between IF/ID and ID/EX.
//    A branch consuming a load result gets BR_LU_BUBBLES bubbles, others 1.
//  - Flushes IF/ID when a branch resolves taken in ID.
//  - Freezes the whole pipeline while data memory is busy.
//  - Keeps saturating counters of bubble cycles and IF/ID flushes.
//
// Ports:
//  clk_i, rst_i          clock, synchronous active-high reset
//  IFID_Opcode_i/RS1/RS2 fields of the instruction in IF/ID
//  IDEX_MemRead_i/RD_i   load flag and destination of the ID/EX instruction
//  Branch_taken_i        branch in ID resolved taken this cycle
//  MemStall_i            data memory busy
//  NoOp_o                bubble request to Control
//  PCWrite_o, IFIDWrite_o front-end load enables
//  Flush_o               clear IF/ID
//  Freeze_o              hold ID/EX, EX/MEM, MEM/WB
//  StallCnt_o, FlushCnt_o performance counters
// ---------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int BR_LU_BUBBLES = 2,
   parameter int CNT_W         = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [6:0]       IFID_Opcode_i,
   input  logic [4:0]       IFID_RS1_i,
   input  logic [4:0]       IFID_RS2_i,
   input  logic             IDEX_MemRead_i,
   input  logic [4:0]       IDEX_RD_i,
   input  logic             Branch_taken_i,
   input  logic             MemStall_i,
   output logic             NoOp_o,
   output logic             PCWrite_o,
   output logic             IFIDWrite_o,
   output logic             Flush_o,
   output logic             Freeze_o,
   output logic [CNT_W-1:0] StallCnt_o,
   output logic [CNT_W-1:0] FlushCnt_o
);

   typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

   // Bubbles still owed after the first one, loaded on a branch load-use.
   localparam logic [2:0]       BR_REM  = 3'(BR_LU_BUBBLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic [2:0]       rem_q, rem_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic [2:0] op_hi;
   logic       uses_rs2;
   logic       is_br;
   logic       lu_hit;

   // R-type, S-type and B-type read rs2; B-type is the branch class.
   assign op_hi    = IFID_Opcode_i[6:4];
   assign uses_rs2 = (op_hi == 3'b011) || (op_hi == 3'b010) || (op_hi == 3'b110);
   assign is_br    = (op_hi == 3'b110);

   // An all-zero opcode is the flushed/empty slot and must never stall.
   assign lu_hit = IDEX_MemRead_i && (IDEX_RD_i != 5'd0) && (IFID_Opcode_i != 7'd0) &&
                   ((IDEX_RD_i == IFID_RS1_i) || (uses_rs2 && (IDEX_RD_i == IFID_RS2_i)));

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= RUN;
         rem_q       <= 3'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      // A memory freeze holds everything, so a stall in progress is extended.
      if (!MemStall_i) begin
         if (state_q == STALL) begin
            rem_d = rem_q - 3'd1;
            if (rem_d == 3'd0) state_d = RUN;
            if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
         end else if (lu_hit) begin
            if (is_br && (BR_LU_BUBBLES > 1)) begin
               state_d = STALL;
               rem_d   = BR_REM;
            end
            if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
         end else if (Branch_taken_i) begin
            if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;
         end
      end
   end

   // Output logic
   always_comb begin
      NoOp_o      = 1'b0;
      PCWrite_o   = 1'b1;
      IFIDWrite_o = 1'b1;
      Flush_o     = 1'b0;
      Freeze_o    = 1'b0;
      if (rst_i) begin
         NoOp_o      = 1'b1;
         PCWrite_o   = 1'b0;
         IFIDWrite_o = 1'b0;
      end else if (MemStall_i) begin
         Freeze_o    = 1'b1;
         PCWrite_o   = 1'b0;
         IFIDWrite_o = 1'b0;
      end else if ((state_q == STALL) || lu_hit) begin
         NoOp_o      = 1'b1;
         PCWrite_o   = 1'b0;
         IFIDWrite_o = 1'b0;
      end else if (Branch_taken_i) begin
         Flush_o     = 1'b1;
      end
   end

   assign StallCnt_o = stall_cnt_q;
   assign FlushCnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   localparam int BR    = 2;
   localparam int CW    = 4;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_i = 1'b0;
   logic [6:0]    IFID_Opcode_i = '0;
   logic [4:0]    IFID_RS1_i = '0;
   logic [4:0]    IFID_RS2_i = '0;
   logic          IDEX_MemRead_i = 1'b0;
   logic [4:0]    IDEX_RD_i = '0;
   logic          Branch_taken_i = 1'b0;
   logic          MemStall_i = 1'b0;
   logic          NoOp_o, PCWrite_o, IFIDWrite_o, Flush_o, Freeze_o;
   logic [CW-1:0] StallCnt_o, FlushCnt_o;

   hazard_ctrl #(.BR_LU_BUBBLES(BR), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .IFID_Opcode_i(IFID_Opcode_i), .IFID_RS1_i(IFID_RS1_i), .IFID_RS2_i(IFID_RS2_i),
      .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_RD_i(IDEX_RD_i),
      .Branch_taken_i(Branch_taken_i), .MemStall_i(MemStall_i),
      .NoOp_o(NoOp_o), .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o),
      .Flush_o(Flush_o), .Freeze_o(Freeze_o),
      .StallCnt_o(StallCnt_o), .FlushCnt_o(FlushCnt_o));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]    ctrl;   // {NoOp, PCWrite, IFIDWrite, Flush, Freeze}
      logic [CW-1:0] sc;
      logic [CW-1:0] fc;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: bubbles still owed and plain integer counters.
   int owed = 0;
   int m_stall = 0;
   int m_flush = 0;

   task automatic cycle(input logic rst, input logic [6:0] op, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic mr, input logic [4:0] rd,
                        input logic bt, input logic ms);
      exp_t e;
      bit   hit, br, r2;
      @(posedge clk);
      #1;
      rst_i = rst; IFID_Opcode_i = op; IFID_RS1_i = rs1; IFID_RS2_i = rs2;
      IDEX_MemRead_i = mr; IDEX_RD_i = rd; Branch_taken_i = bt; MemStall_i = ms;
      br  = (op[6:4] == 3'b110);
      r2  = br || (op[6:4] == 3'b011) || (op[6:4] == 3'b010);
      hit = mr && rd != 0 && op != 0 && (rd == rs1 || (r2 && rd == rs2));
      e.sc = CW'(m_stall);
      e.fc = CW'(m_flush);
      if (rst) begin
         e.ctrl = 5'b10000;
         owed = 0; m_stall = 0; m_flush = 0;
      end else if (ms) begin
         e.ctrl = 5'b00001;
      end else if (owed > 0) begin
         e.ctrl = 5'b10000;
         owed--;
         m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      end else if (hit) begin
         e.ctrl = 5'b10000;
         owed = br ? BR - 1 : 0;
         m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      end else if (bt) begin
         e.ctrl = 5'b01110;
         m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      end else begin
         e.ctrl = 5'b01100;
      end
      exp_q.push_back(e);
   endtask

   task automatic idle();
      cycle(0, 7'b0110011, 5'd1, 5'd2, 0, 5'd0, 0, 0);
   endtask

   // Monitor: outputs are valid every cycle; sample mid-cycle and score.
   initial begin
      exp_t e;
      logic [4:0] act;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {NoOp_o, PCWrite_o, IFIDWrite_o, Flush_o, Freeze_o};
            n_cmp++;
            if (act !== e.ctrl) begin
               n_bad++;
               $display("FAIL ctrl @%0t: got %b want %b", $time, act, e.ctrl);
            end
            n_cmp++;
            if (StallCnt_o !== e.sc || FlushCnt_o !== e.fc) begin
               n_bad++;
               $display("FAIL counters @%0t: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                        $time, StallCnt_o, FlushCnt_o, e.sc, e.fc);
            end
         end
      end
   end

   initial begin
      logic [6:0] ops [8];
      int w;
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
              7'b1100011, 7'b0000000, 7'b1101111, 7'b1100111};
      // Reset then idle
      cycle(1, 7'd0, 0, 0, 0, 0, 0, 0);
      cycle(1, 7'd0, 0, 0, 0, 0, 0, 0);
      idle(); idle();
      // Load-use on add via rs2, then rd = x0
      cycle(0, 7'b0110011, 5'd1, 5'd5, 1, 5'd5, 0, 0);
      idle(); idle();
      cycle(0, 7'b0110011, 5'd0, 5'd0, 1, 5'd0, 0, 0);
      idle();
      // Branch load-use, taken branch ignored in the second bubble
      cycle(0, 7'b1100011, 5'd7, 5'd1, 1, 5'd7, 0, 0);
      cycle(0, 7'b1100011, 5'd7, 5'd1, 0, 5'd0, 1, 0);
      idle(); idle();
      // Taken branch alone, then together with a load-use hit
      cycle(0, 7'b1100011, 5'd1, 5'd2, 0, 5'd0, 1, 0);
      idle();
      cycle(0, 7'b0110011, 5'd3, 5'd4, 1, 5'd3, 1, 0);
      idle(); idle();
      // Freeze mid-stall
      cycle(0, 7'b1100011, 5'd7, 5'd1, 1, 5'd7, 0, 0);
      repeat (3) cycle(0, 7'b1100011, 5'd7, 5'd1, 0, 5'd0, 0, 1);
      idle(); idle();
      // Reset mid-stall
      cycle(0, 7'b1100011, 5'd7, 5'd1, 1, 5'd7, 0, 0);
      cycle(1, 7'b1100011, 5'd7, 5'd1, 0, 5'd0, 0, 0);
      idle(); idle();
      // Saturation of the stall counter
      for (int i = 0; i < 20; i++) begin
         cycle(0, 7'b0000011, 5'd9, 5'd0, 1, 5'd9, 0, 0);
         idle();
      end
      // Randomized traffic with small register indices to provoke hits
      cycle(1, 7'd0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 800; i++) begin
         cycle(($urandom_range(0, 99) < 2),
               ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 7)],
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) < 15));
      end
      w = 0;
      while (exp_q.size() > 0 && w < 20) begin
         @(negedge clk); #1;
         w++;
      end
      if (exp_q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller in the ID stage of the 5-stage RV32 core.
- Detects load-use hazards between the IF/ID instruction and the load in ID/EX, and inserts bubbles by driving NoOp into Control.
- Freezes PC and IF/ID, and flushes IF/ID on branches taken in ID.
- Propagates a global freeze while data memory is busy, and keeps saturating stall and flush performance counters.

Parameters:
- BR_LU_BUBBLES, 2, bubbles inserted when a branch in ID consumes a load result in EX; legal range 1..7.
- CNT_W, 16, width of each performance counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- IFID_Opcode_i  in  7  opcode field of the instruction in IF/ID
- IFID_RS1_i  in  5  rs1 of the IF/ID instruction
- IFID_RS2_i  in  5  rs2 of the IF/ID instruction
- IDEX_MemRead_i  in  1  instruction in ID/EX is a load
- IDEX_RD_i  in  5  rd of the ID/EX instruction
- Branch_taken_i  in  1  branch in ID resolved taken this cycle
- MemStall_i  in  1  data memory busy; whole pipeline must hold
- NoOp_o  out  1  to Control: zero all control signals (bubble)
- PCWrite_o  out  1  PC update enable
- IFIDWrite_o  out  1  IF/ID load enable
- Flush_o  out  1  clear IF/ID to all-zero instruction
- Freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB
- StallCnt_o  out  CNT_W  bubble cycles inserted
- FlushCnt_o  out  CNT_W  IF/ID flushes issued

Behaviour:
- Derived signals (combinational):
  - uses_rs2 = IFID_Opcode_i[6:4] in {011, 010, 110}.
  - is_br = IFID_Opcode_i[6:4] == 110.
  - lu_hit = IDEX_MemRead_i & (IDEX_RD_i != 0) & ((IDEX_RD_i == IFID_RS1_i) | (uses_rs2 & (IDEX_RD_i == IFID_RS2_i))).
  - An opcode of 0000000 never hits.
- States: RUN and STALL, plus a 3-bit remaining-bubble counter rem.
- Outputs are combinational from state and inputs; state, rem and both counters are registered.
- Priority, highest first:
  - rst_i = 1: NoOp_o=1, PCWrite_o=0, IFIDWrite_o=0, Flush_o=0, Freeze_o=0. Next state RUN, rem=0, StallCnt_o=0, FlushCnt_o=0.
  - MemStall_i = 1 (any state): Freeze_o=1, PCWrite_o=0, IFIDWrite_o=0, NoOp_o=0, Flush_o=0. State, rem and counters hold. Branch_taken_i and lu_hit are ignored.
  - STALL: NoOp_o=1, PCWrite_o=0, IFIDWrite_o=0, Flush_o=0. StallCnt_o+1. rem-1; when rem reaches 0, next state is RUN. Branch_taken_i is ignored.
  - RUN with lu_hit: NoOp_o=1, PCWrite_o=0, IFIDWrite_o=0, Flush_o=0, StallCnt_o+1. If is_br and BR_LU_BUBBLES > 1, go to STALL with rem = BR_LU_BUBBLES-1; otherwise stay in RUN.
  - RUN with Branch_taken_i and no lu_hit: Flush_o=1, PCWrite_o=1, IFIDWrite_o=1, NoOp_o=0, FlushCnt_o+1.
  - RUN idle: PCWrite_o=1, IFIDWrite_o=1, all other outputs 0.
- Total bubble latency:
  - Non-branch load-use: exactly 1 cycle.
  - Branch load-use: exactly BR_LU_BUBBLES cycles, not counting freeze cycles.
- Counters saturate at 2^CNT_W-1; no wrap.
- Reset asserted mid-STALL aborts the stall in the same cycle (reset outputs apply) and the block resumes in RUN.
- A freeze that arrives mid-STALL extends the stall without consuming rem.

Test Plan:
1. Reset: rst_i=1 for 2 cycles, then 0 with no hazard inputs → NoOp_o=1 during reset; afterwards PCWrite_o=IFIDWrite_o=1, counters 0.
2. Load-use on add: IDEX_MemRead_i=1, IDEX_RD_i=5, IFID_Opcode_i=0110011, IFID_RS2_i=5, for one cycle → exactly 1 cycle with NoOp_o=1 and PCWrite_o=0; StallCnt_o=1. Repeat with IDEX_RD_i=0 → no stall.
3. Branch load-use: IFID_Opcode_i=1100011, IFID_RS1_i=7, IDEX_MemRead_i=1, IDEX_RD_i=7 (present in cycle 0 only) → NoOp_o=1 in cycles 0 and 1; Branch_taken_i=1 in cycle 1 gives Flush_o=0; StallCnt_o=2.
4. Taken branch: Branch_taken_i=1 with no hazard → Flush_o=1 and PCWrite_o=1 for 1 cycle, FlushCnt_o=1. Simultaneous lu_hit → Flush_o=0, NoOp_o=1.
5. Memory stall mid-STALL: scenario 3 with MemStall_i=1 for 3 cycles starting in cycle 1 → Freeze_o=1 and NoOp_o=0 for 3 cycles, then 1 further bubble; StallCnt_o=2.
6. Saturation with CNT_W=4: 20 isolated load-use hazards → StallCnt_o=15 and stays 15.
